// File: rtl/spike_time_encoder.sv
// spike_time_encoder: binary value vector -> race-logic spike times.
// Also frames gamma cycles with start and local-reset pulses.
//
// Ports:
//   aclk, grst_n   clock, async active-low reset
//   in_valid/ready one-entry staging buffer handshake
//   in_data        channel i value in [i*VAL_W +: VAL_W]
//   in_null        1 = channel i never spikes
//   spike          per-channel temporal outputs
//   gamma_start    slot t=0 of an active gamma cycle
//   gamma_rst      slot t=G-1, drives downstream latch reset
//   busy           high in every RUN slot
module spike_time_encoder #(
  parameter int N_CH = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH = 8,
  localparam int VAL_W = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic                   aclk,
  input  logic                   grst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_CH*VAL_W-1:0]  in_data,
  input  logic [N_CH-1:0]        in_null,
  output logic [N_CH-1:0]        spike,
  output logic                   gamma_start,
  output logic                   gamma_rst,
  output logic                   busy
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [VAL_W-1:0] T_LAST =
    VAL_W'(GAMMA_CYCLE_WIDTH - 1);

  state_t                state;
  state_t                state_nxt;
  logic [VAL_W-1:0]      t_q;
  logic [VAL_W-1:0]      t_nxt;
  logic                  stage_full;
  logic                  stage_full_nxt;
  logic [N_CH*VAL_W-1:0] stage_data;
  logic [N_CH-1:0]       stage_null;
  logic [N_CH*VAL_W-1:0] act_data;
  logic [N_CH*VAL_W-1:0] act_data_nxt;
  logic [N_CH-1:0]       act_null;
  logic [N_CH-1:0]       act_null_nxt;
  logic [N_CH-1:0]       spike_nxt;
  logic                  take;
  logic                  load;
  logic                  run_nxt;

  // in_ready is registered from ~stage_full, so a load and a new
  // transfer can never share an edge: no bypass path exists.
  assign take = in_valid && in_ready;

  // Gamma boundary: idle, or last slot of a running cycle.
  assign load = stage_full &&
                ((state == IDLE) || (t_q == T_LAST));

  always_comb begin
    state_nxt      = state;
    t_nxt          = t_q;
    stage_full_nxt = stage_full;
    act_data_nxt   = act_data;
    act_null_nxt   = act_null;
    if (load) begin
      state_nxt      = RUN;
      t_nxt          = '0;
      stage_full_nxt = 1'b0;
      act_data_nxt   = stage_data;
      act_null_nxt   = stage_null;
    end else if (state == RUN && t_q != T_LAST) begin
      t_nxt = t_q + VAL_W'(1);
    end else begin
      state_nxt = IDLE;
      t_nxt     = '0;
    end
    if (take) begin
      stage_full_nxt = 1'b1;
    end
  end

  assign run_nxt = (state_nxt == RUN);

  // Outputs are registered from next-slot values so that each
  // output cycle lines up with the counter value it belongs to.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [VAL_W-1:0] v;
    logic             v_ok;
    logic             past;
    logic             in_win;

    assign v = act_data_nxt[i*VAL_W +: VAL_W];

    // Values beyond the gamma length can only arise for
    // non-power-of-2 G; they mean "never fires".
    assign v_ok = !act_null_nxt[i] &&
                  (int'(v) < GAMMA_CYCLE_WIDTH);

    assign past = (t_nxt >= v);

    // t never exceeds G-1, so pulses truncate at gamma end.
    assign in_win = (PULSE_WIDTH == 0) ||
                    ((int'(t_nxt) - int'(v)) < PULSE_WIDTH);

    assign spike_nxt[i] = run_nxt && v_ok && past && in_win;
  end

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      state       <= IDLE;
      t_q         <= '0;
      stage_full  <= 1'b0;
      stage_data  <= '0;
      stage_null  <= '0;
      act_data    <= '0;
      act_null    <= '0;
      in_ready    <= 1'b1;
      spike       <= '0;
      gamma_start <= 1'b0;
      gamma_rst   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state      <= state_nxt;
      t_q        <= t_nxt;
      stage_full <= stage_full_nxt;
      if (take) begin
        stage_data <= in_data;
        stage_null <= in_null;
      end
      act_data    <= act_data_nxt;
      act_null    <= act_null_nxt;
      in_ready    <= !stage_full_nxt;
      spike       <= spike_nxt;
      gamma_start <= run_nxt && (t_nxt == '0);
      gamma_rst   <= run_nxt && (t_nxt == T_LAST);
      busy        <= run_nxt;
    end
  end

endmodule
